// File: rtl/pcpi_nibble_sequencer_pkg.sv
// Shared constants and FSM state encoding for the PCPI nibble sequencer.
package pcpi_nibble_sequencer_pkg;

    localparam int NIBBLES_PER_WORD = 8;
    localparam int TIMEOUT_DEFAULT  = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10
    } state_t;

endpackage

// File: rtl/pcpi_nibble_sequencer_shift_reg.sv
// Word register with nibble-indexed load, whole-word capture and nibble-indexed read.
import pcpi_nibble_sequencer_pkg::*;

module nibble_shift_reg #(
    parameter int NIBBLES = NIBBLES_PER_WORD,
    parameter int IDX_W   = $clog2(NIBBLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [3:0]           load_nib,
    input  logic                 cap_en,
    input  logic [4*NIBBLES-1:0] cap_word,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [4*NIBBLES-1:0] word,
    output logic [3:0]           rd_nib
);

    // NOTE: the storage is cleared by reset so no stale nibble of an aborted
    // instruction or undrained result can leak into the next transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
        end else if (cap_en) begin
            word <= cap_word;
        end else if (load_en) begin
            word[{load_idx, 2'b00} +: 4] <= load_nib;
        end
    end

    assign rd_nib = word[{rd_idx, 2'b00} +: 4];

endmodule

// File: rtl/pcpi_nibble_sequencer.sv
// Assembles a PCPI instruction from host nibbles, issues it, and streams the result back.
import pcpi_nibble_sequencer_pkg::*;

module pcpi_nibble_sequencer #(
    parameter int NIBBLES = NIBBLES_PER_WORD,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           nib_in,
    input  logic                 nib_strobe,
    output logic                 nib_ack,
    output logic                 pcpi_valid,
    output logic [4*NIBBLES-1:0] pcpi_insn,
    input  logic                 pcpi_ready,
    input  logic                 pcpi_wr,
    input  logic                 pcpi_wait,
    input  logic [4*NIBBLES-1:0] pcpi_rd,
    output logic [3:0]           res_nib,
    output logic                 res_valid,
    input  logic                 res_take,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] nib_cnt, res_cnt;
    logic [7:0]       to_cnt;
    logic             accept, issue_done, result_wr, abort, xfer;
    logic [3:0]       result_nib;
    logic [3:0]       insn_nib_unused;
    logic [4*NIBBLES-1:0] result_word_unused;

    // Acceptance needs ack low so a strobe held high counts as one nibble.
    assign accept     = (state == LOAD) && nib_strobe && !nib_ack;
    assign issue_done = (state == ISSUE) && pcpi_ready;
    assign result_wr  = issue_done && pcpi_wr;
    assign abort      = (state == ISSUE) && !pcpi_ready && !pcpi_wait &&
                        (to_cnt == 8'(TIMEOUT - 1));
    assign xfer       = res_valid && res_take;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values; the comb block below uses blocking ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (accept && nib_cnt == LAST_IDX) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (issue_done)  state_nxt = pcpi_wr ? DRAIN : LOAD;
                else if (abort)  state_nxt = LOAD;
            end
            DRAIN: begin
                if (xfer && res_cnt == LAST_IDX) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nib_cnt <= '0;
            res_cnt <= '0;
            to_cnt  <= '0;
            nib_ack <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (accept) nib_cnt <= nib_cnt + IDX_W'(1);
            if (xfer)   res_cnt <= res_cnt + IDX_W'(1);

            // A pending ack completes its fall even after leaving LOAD.
            if (accept)           nib_ack <= 1'b1;
            else if (!nib_strobe) nib_ack <= 1'b0;

            if (state != ISSUE || pcpi_wait) to_cnt <= '0;
            else                             to_cnt <= to_cnt + 8'd1;

            if (abort)       timeout <= 1'b1;
            else if (accept) timeout <= 1'b0;
        end
    end

    nibble_shift_reg #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_insn_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (accept),
        .load_idx (nib_cnt),
        .load_nib (nib_in),
        .cap_en   (1'b0),
        .cap_word ('0),
        .rd_idx   ('0),
        .word     (pcpi_insn),
        .rd_nib   (insn_nib_unused)
    );

    nibble_shift_reg #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_result_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (1'b0),
        .load_idx ('0),
        .load_nib (4'h0),
        .cap_en   (result_wr),
        .cap_word (pcpi_rd),
        .rd_idx   (res_cnt),
        .word     (result_word_unused),
        .rd_nib   (result_nib)
    );

    assign pcpi_valid = (state == ISSUE);
    assign res_valid  = (state == DRAIN);
    assign busy       = (state != LOAD);
    assign res_nib    = res_valid ? result_nib : 4'h0;

endmodule

// File: tb/tb_pcpi_nibble_sequencer.sv
// Directed bench for pcpi_nibble_sequencer with instruction/result scoreboards.
module tb_pcpi_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  nib_in = 4'h0;
    logic        nib_strobe = 1'b0;
    logic        nib_ack;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_ready = 1'b0;
    logic        pcpi_wr = 1'b0;
    logic        pcpi_wait = 1'b1;
    logic [31:0] pcpi_rd = 32'h0;
    logic [3:0]  res_nib;
    logic        res_valid;
    logic        res_take = 1'b0;
    logic        busy;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic [31:0] insn_q[$];
    logic [3:0]  res_q[$];

    pcpi_nibble_sequencer #(.NIBBLES(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nib_in     (nib_in),
        .nib_strobe (nib_strobe),
        .nib_ack    (nib_ack),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_ready (pcpi_ready),
        .pcpi_wr    (pcpi_wr),
        .pcpi_wait  (pcpi_wait),
        .pcpi_rd    (pcpi_rd),
        .res_nib    (res_nib),
        .res_valid  (res_valid),
        .res_take   (res_take),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pcpi_valid"}, 32'(pcpi_valid), 0);
        check({tag, "_nib_ack"},    32'(nib_ack),    0);
        check({tag, "_res_valid"},  32'(res_valid),  0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_timeout"},    32'(timeout),    0);
        check({tag, "_res_nib"},    32'(res_nib),    0);
        check({tag, "_pcpi_insn"},  pcpi_insn,       0);
    endtask

    // Four-phase transfer of one nibble; checks pcpi_valid right after acceptance.
    task automatic send_nib(input logic [3:0] n, input logic exp_valid, input string tag);
        logic got;
        @(negedge clk);
        nib_in = n;
        nib_strobe = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (nib_ack === 1'b1) begin got = 1'b1; break; end
        end
        check({tag, "_ack_rise"}, 32'(got), 1);
        check({tag, "_valid_after_accept"}, 32'(pcpi_valid), 32'(exp_valid));
        accept_cyc = cyc;
        @(negedge clk);
        nib_strobe = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (nib_ack === 1'b0) begin got = 1'b1; break; end
        end
        check({tag, "_ack_fall"}, 32'(got), 1);
    endtask

    task automatic load_word(input logic [31:0] w, input int start, input string tag);
        logic [31:0] exp_insn;
        insn_q.push_back(w);
        for (int k = start; k < 8; k++) send_nib(w[4*k +: 4], k == 7, tag);
        exp_insn = insn_q.pop_front();
        check({tag, "_insn"}, pcpi_insn, exp_insn);
    endtask

    task automatic issue_ready(input logic wr, input logic [31:0] rd, input string tag);
        @(negedge clk);
        pcpi_ready = 1'b1;
        pcpi_wr = wr;
        pcpi_rd = rd;
        if (wr) for (int k = 0; k < 8; k++) res_q.push_back(rd[4*k +: 4]);
        @(posedge clk); #1;
        check({tag, "_valid_low"}, 32'(pcpi_valid), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'(wr));
        check({tag, "_busy"}, 32'(busy), 32'(wr));
        @(negedge clk);
        pcpi_ready = 1'b0;
        pcpi_wr = 1'b0;
        pcpi_rd = 32'hDEAD_BEEF;
    endtask

    // Drains the result with an irregular res_take pattern.
    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_q.size() == 0) break;
            if (res_valid === 1'b1) begin
                check({tag, "_res_nib"}, 32'(res_nib), 32'(res_q[0]));
                res_take = ((i % 3) != 1);
                if (res_take) void'(res_q.pop_front());
            end else begin
                res_take = 1'b0;
            end
        end
        res_take = 1'b0;
        check({tag, "_all_drained"}, 32'(res_q.size()), 0);
        check({tag, "_res_valid_after"}, 32'(res_valid), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        logic got;
        logic seen_ack;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // PCPI completion signals are ignored while loading.
        @(negedge clk);
        pcpi_ready = 1'b1;
        pcpi_wr = 1'b1;
        pcpi_rd = 32'h1234_5678;
        @(posedge clk); #1;
        check("ready_in_load_busy", 32'(busy), 0);
        check("ready_in_load_res_valid", 32'(res_valid), 0);
        @(negedge clk);
        pcpi_ready = 1'b0;
        pcpi_wr = 1'b0;

        // Basic load and result drain.
        load_word(32'hCDEF_0123, 0, "load1");
        check("load1_busy", 32'(busy), 1);
        repeat (3) @(posedge clk);
        #1;
        check("load1_valid_held", 32'(pcpi_valid), 1);
        issue_ready(1'b1, 32'hA5A5_1234, "issue1");
        drain("drain1");

        // Timeout abort while the coprocessor never claims the instruction.
        pcpi_wait = 1'b0;
        load_word(32'h8765_4321, 0, "load_to");
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (pcpi_valid === 1'b0) begin got = 1'b1; break; end
        end
        check("to_dropped", 32'(got), 1);
        check("to_valid_cycles", 32'(cyc - accept_cyc), 16);
        check("to_flag_set", 32'(timeout), 1);
        check("to_busy", 32'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("to_flag_sticky", 32'(timeout), 1);
        send_nib(4'h7, 1'b0, "to_clear");
        check("to_flag_cleared", 32'(timeout), 0);

        // Completion without a write returns straight to LOAD.
        pcpi_wait = 1'b1;
        load_word(32'h1357_9BD7, 1, "load_nowr");
        issue_ready(1'b0, 32'hFFFF_FFFF, "issue_nowr");
        repeat (3) @(posedge clk);
        #1;
        check("nowr_res_valid_idle", 32'(res_valid), 0);

        // Strobe held high for ten cycles counts as one nibble.
        @(negedge clk);
        nib_in = 4'h9;
        nib_strobe = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            nib_in = 4'(i);
        end
        check("held_ack_high", 32'(nib_ack), 1);
        nib_strobe = 1'b0;
        @(posedge clk); #1;
        check("held_ack_fall", 32'(nib_ack), 0);
        load_word(32'h2468_ACE9, 1, "load_held");

        // Strobe outside LOAD raises no acknowledge and changes nothing.
        @(negedge clk);
        nib_in = 4'h5;
        nib_strobe = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen_ack = seen_ack | nib_ack;
        end
        check("issue_strobe_no_ack", 32'(seen_ack), 0);
        check("issue_strobe_insn", pcpi_insn, 32'h2468_ACE9);
        @(negedge clk);
        nib_strobe = 1'b0;
        issue_ready(1'b1, 32'h0F1E_2D3C, "issue2");
        drain("drain2");

        // Reset in the middle of an instruction discards the partial load.
        send_nib(4'hA, 1'b0, "part0");
        send_nib(4'hB, 1'b0, "part1");
        send_nib(4'hC, 1'b0, "part2");
        send_nib(4'hD, 1'b0, "part3");
        send_nib(4'hE, 1'b0, "part4");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        load_word(32'h9080_7060, 0, "reload");
        issue_ready(1'b0, 32'h0, "issue_reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcpi_nibble_sequencer.md
PCPI_NIBBLE_SEQUENCER -- requirements
Module: pcpi_nibble_sequencer

Interface
REQ-001 Parameter NIBBLES, default 8, nibbles per 32-bit instruction and per result word (fixed 8; other values unsupported).
REQ-002 Parameter TIMEOUT, default 16, ISSUE-state cycles allowed with pcpi_wait low before abort; range 2..255.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 nib_in  in  4  host instruction nibble.
REQ-006 nib_strobe  in  1  host level strobe; nib_in is valid while it is high.
REQ-007 nib_ack  out  1  four-phase acknowledge of an accepted nibble.
REQ-008 pcpi_valid  out  1  PCPI request to the coprocessor.
REQ-009 pcpi_insn  out  32  assembled instruction, stable while pcpi_valid is high.
REQ-010 pcpi_ready  in  1  coprocessor completion, one-cycle pulse.
REQ-011 pcpi_wr  in  1  result-write flag, qualified by pcpi_ready.
REQ-012 pcpi_wait  in  1  coprocessor claims the instruction and is busy.
REQ-013 pcpi_rd  in  32  coprocessor result, qualified by pcpi_ready.
REQ-014 res_nib  out  4  result nibble to host.
REQ-015 res_valid  out  1  res_nib is valid.
REQ-016 res_take  in  1  host consumes res_nib; a transfer occurs when res_valid and res_take are both high.
REQ-017 busy  out  1  high in any state other than LOAD.
REQ-018 timeout  out  1  sticky abort flag.

Function
REQ-019 FSM states: LOAD, ISSUE, DRAIN.
REQ-020 LOAD nibble acceptance:
- A nibble is accepted on a cycle with nib_strobe=1 and nib_ack=0.
- nib_ack rises the next cycle and holds until nib_strobe is sampled low, then falls the next cycle.
- A strobe held high for many cycles counts as exactly one nibble.
REQ-021 Nibble k (0..7) is written to pcpi_insn[4k+3:4k], LSB nibble first.
REQ-022 The 8th accepted nibble (count wraps 7 to 0) moves the FSM to ISSUE; pcpi_valid is high the cycle after the acceptance edge.
REQ-023 Outside LOAD, nib_strobe is ignored: no acceptance and no new nib_ack rise, but a pending nib_ack still completes its four-phase fall.
REQ-024 ISSUE: pcpi_valid stays high until a cycle with pcpi_ready=1, including the first ISSUE cycle.
- At that edge, pcpi_valid falls.
- If pcpi_wr=1, pcpi_rd is captured and the FSM goes to DRAIN; otherwise it goes to LOAD.
REQ-025 Timeout counter:
- Clears on ISSUE entry and on every cycle with pcpi_wait=1; otherwise increments each ISSUE cycle.
- Reaching TIMEOUT without pcpi_ready drops pcpi_valid, sets timeout, and returns to LOAD.
- pcpi_ready wins over timeout in the same cycle.
REQ-026 pcpi_ready, pcpi_wr and pcpi_rd are ignored outside ISSUE.
REQ-027 DRAIN presents res_nib = result[4j+3:4j] with res_valid=1, for j = 0..7.
- Each transfer advances j.
- The 8th transfer returns the FSM to LOAD with res_valid low the next cycle.
REQ-028 timeout clears on the first nibble accepted after it was set.
REQ-029 The nibble and result counters are 3-bit and wrap; no other counter wraps.

Reset
REQ-030 While rst_n=0 at a clock edge, all of the following are cleared: state=LOAD, both counters, the timeout counter, pcpi_valid, nib_ack, res_valid, timeout, busy, pcpi_insn and the result register; res_nib=0.
REQ-031 Reset mid-operation discards partial instructions and undrained results; an outstanding PCPI request is dropped without waiting for pcpi_ready.

Structure
REQ-032 A shared package holds the state encoding (LOAD=2'b00, ISSUE=2'b01, DRAIN=2'b10), the NIBBLES constant and the TIMEOUT default.
REQ-033 One sub-module, nibble_shift_reg, implements 32-bit nibble load and unload indexed by a 3-bit counter; it is instantiated twice (instruction and result).

Verification
REQ-034 Load nibbles 3,2,1,0,F,E,D,C (4-phase) -> pcpi_insn=32'hCDEF0123, pcpi_valid high the cycle after the 8th acceptance.
REQ-035 In ISSUE, pulse pcpi_ready with pcpi_wr=1 and pcpi_rd=32'hA5A5_1234 -> pcpi_valid low next cycle; DRAIN emits 4,3,2,1,5,A,5,A; then LOAD with busy=0.
REQ-036 Hold pcpi_wait=0 in ISSUE with TIMEOUT=16 -> pcpi_valid drops after 16 cycles, timeout=1; the next accepted nibble clears timeout.
REQ-037 Hold nib_strobe high for 10 cycles -> exactly one nibble accepted and nib_ack high until the strobe drops.
REQ-038 Assert rst_n=0 after 5 nibbles, then reload 8 nibbles -> the new instruction contains no stale nibbles; all outputs read 0 during reset.
REQ-039 Pulse pcpi_ready with pcpi_wr=0 -> no DRAIN, res_valid stays 0, return to LOAD.
